// File: rtl/output_ctrl_pkg.sv
// Shared types and constants for the output drain controller.
// Holds the FSM state encoding and the activation-mode codes.
// Build option: OUTPUT_DRAIN_ROW_STRIDE_EN (see drain_addr_gen).
package output_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_RELU6 = 2'd2;

  // Code 3 is reserved and behaves exactly like "no activation".
  function automatic logic [1:0] act_decode(input logic [1:0] mode);
    return ((mode == ACT_RELU) || (mode == ACT_RELU6)) ? mode : ACT_NONE;
  endfunction

endpackage

// File: rtl/output_drain_control_if.sv
// Row-write bus from the drain controller to the output buffer / activation unit.
// Ports: wr_valid/wr_ready handshake, wr_en lane mask, replicated wr_addr,
//        row_num (accumulator row) and act_sel; master = controller, slave = buffer.
interface output_drain_control_if #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8
);
  localparam int R_W = $clog2(SYS_ARR_ROWS);

  logic                               wr_valid;
  logic                               wr_ready;
  logic [SYS_ARR_COLS-1:0]            wr_en;
  logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] wr_addr;
  logic [R_W-1:0]                     row_num;
  logic [1:0]                         act_sel;

  modport master (
    output wr_valid, wr_en, wr_addr, row_num, act_sel,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_en, wr_addr, row_num, act_sel,
    output wr_ready
  );

endinterface

// File: rtl/drain_addr_gen.sv
// Row counter and output-buffer address generator for one drain job.
// Ports: load (latch base/stride, clear count), advance (next row), count, wr_addr
//        replicated per lane. OUTPUT_DRAIN_ROW_STRIDE_EN selects latched stride vs 1.
module drain_addr_gen
  import output_ctrl_pkg::*;
#(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8,
  localparam int R_W = $clog2(SYS_ARR_ROWS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic                               advance,
  input  logic [ADDR_WIDTH-1:0]              base,
  input  logic [ADDR_WIDTH-1:0]              stride,
  output logic [R_W-1:0]                     count,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] wr_addr
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] step;

`ifdef OUTPUT_DRAIN_ROW_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stride_q <= '0;
    end else if (load) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  logic unused_stride;
  assign unused_stride = ^stride;
  assign step          = ADDR_WIDTH'(1);
`endif

  // Running address: base + count*step is built incrementally, wrapping mod 2^ADDR_WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      count  <= '0;
    end else if (load) begin
      addr_q <= base;
      count  <= '0;
    end else if (advance) begin
      addr_q <= addr_q + step;
      count  <= count + R_W'(1);
    end
  end

  assign wr_addr = {SYS_ARR_COLS{addr_q}};

endmodule

// File: rtl/output_drain_control.sv
// Drains one accumulator submatrix into the output buffer, one row per accepted cycle,
// with start/busy/done handshake, wr_valid/wr_ready back-pressure and optional clear.
// Ports: clk, reset (async low), job inputs latched on start, wr bus interface (master).
// Build option OUTPUT_DRAIN_ROW_STRIDE_EN enables the programmable row_stride.
module output_drain_control
  import output_ctrl_pkg::*;
#(
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8,
  localparam int SM_W = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS),
  localparam int SN_W = $clog2(MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int R_W  = $clog2(SYS_ARR_ROWS),
  localparam int C_W  = $clog2(SYS_ARR_COLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [SM_W-1:0]       submat_row_in,
  input  logic [SN_W-1:0]       submat_col_in,
  output logic [SM_W-1:0]       submat_row_out,
  output logic [SN_W-1:0]       submat_col_out,
  input  logic [R_W-1:0]        num_rows_m1,
  input  logic [C_W-1:0]        num_cols_m1,
  input  logic [1:0]            act_mode,
  input  logic                  clear_after,
  output logic                  accum_reset,
  input  logic [ADDR_WIDTH-1:0] wr_base_addr,
  input  logic [ADDR_WIDTH-1:0] row_stride,
  output_drain_control_if.master wr
);

  state_t state_q, state_d;
  logic   done_d;

  logic [R_W-1:0] nrows_q;
  logic [C_W-1:0] ncols_q;
  logic [1:0]     act_q;
  logic           clear_q;
  logic [R_W-1:0] count;

  logic load, accept, last_row, advance;
  logic [SYS_ARR_COLS-1:0]            lane_en;
  logic                               valid_c;
  logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] addr_rep;

  assign load     = (state_q == IDLE) && start;
  assign accept   = (state_q == DRAIN) && wr.wr_ready;
  assign last_row = (count == nrows_q);
  assign advance  = accept && !last_row;

  // State register; done is registered so it lands in the first IDLE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = DRAIN;
      end
      DRAIN: begin
        if (accept && last_row) begin
          if (clear_q) begin
            state_d = CLEAR;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    busy        = (state_q != IDLE);
    valid_c     = (state_q == DRAIN);
    accum_reset = (state_q == CLEAR);
    lane_en     = '0;
    for (int i = 0; i < SYS_ARR_COLS; i++) begin
      lane_en[i] = valid_c && (C_W'(i) <= ncols_q);
    end
  end

  // Job parameters are captured once; inputs are ignored for the rest of the job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nrows_q        <= '0;
      ncols_q        <= '0;
      act_q          <= ACT_NONE;
      clear_q        <= 1'b0;
      submat_row_out <= '0;
      submat_col_out <= '0;
    end else if (load) begin
      nrows_q        <= num_rows_m1;
      ncols_q        <= num_cols_m1;
      act_q          <= act_decode(act_mode);
      clear_q        <= clear_after;
      submat_row_out <= submat_row_in;
      submat_col_out <= submat_col_in;
    end
  end

  drain_addr_gen #(
    .SYS_ARR_ROWS (SYS_ARR_ROWS),
    .SYS_ARR_COLS (SYS_ARR_COLS),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .base    (wr_base_addr),
    .stride  (row_stride),
    .count   (count),
    .wr_addr (addr_rep)
  );

  assign wr.wr_valid = valid_c;
  assign wr.wr_en    = lane_en;
  assign wr.wr_addr  = addr_rep;
  assign wr.row_num  = count;
  assign wr.act_sel  = act_q;

endmodule

// File: tb/tb_output_drain_control.sv
// Directed bench for output_drain_control: reset, full drain, partial drain with clear,
// back-pressure, stride/wrap, start handshake and asynchronous reset mid-drain.
// Inputs change and outputs are checked on the falling clock edge.
module tb_output_drain_control;
  import output_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        busy, done;
  logic [2:0]  sr_in, sc_in, sr_out, sc_out;
  logic [3:0]  nrows, ncols;
  logic [1:0]  act_mode;
  logic        clear_after;
  logic        accum_reset;
  logic [7:0]  base, stride;

  output_drain_control_if #(.SYS_ARR_ROWS(16), .SYS_ARR_COLS(16), .ADDR_WIDTH(8)) wr_if ();

  output_drain_control dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .submat_row_in  (sr_in),
    .submat_col_in  (sc_in),
    .submat_row_out (sr_out),
    .submat_col_out (sc_out),
    .num_rows_m1    (nrows),
    .num_cols_m1    (ncols),
    .act_mode       (act_mode),
    .clear_after    (clear_after),
    .accum_reset    (accum_reset),
    .wr_base_addr   (base),
    .row_stride     (stride),
    .wr             (wr_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // {busy, done, wr_valid, accum_reset}
  logic [3:0]   ctrl;
  logic [127:0] exp_addr;
  assign ctrl = {busy, done, wr_if.wr_valid, accum_reset};

  // Present a job at the current falling edge, pulse start across one rising edge,
  // then scramble the inputs so only latched values can influence the job.
  task automatic start_job(input logic [3:0] r, input logic [3:0] c, input logic [7:0] b,
                           input logic [7:0] s, input logic [1:0] m, input logic clr,
                           input logic [2:0] srow, input logic [2:0] scol);
    nrows = r; ncols = c; base = b; stride = s; act_mode = m;
    clear_after = clr; sr_in = srow; sc_in = scol; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nrows = 4'h0; ncols = 4'h0; base = 8'hAA; stride = 8'h55; act_mode = 2'd0;
    clear_after = ~clr; sr_in = 3'd7; sc_in = 3'd7;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; wr_if.wr_ready = 1'b1;
    nrows = 0; ncols = 0; base = 0; stride = 0; act_mode = 0;
    clear_after = 0; sr_in = 0; sc_in = 0;
    #1;
    n_cmp++;
    if ({ctrl, wr_if.act_sel, wr_if.row_num, sr_out, sc_out} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %h want 0", {ctrl, wr_if.act_sel, wr_if.row_num, sr_out, sc_out});
    end
    n_cmp++;
    if ({wr_if.wr_en, wr_if.wr_addr} !== 144'h0) begin
      n_err++;
      $display("FAIL reset_bus: got en %h addr %h want 0", wr_if.wr_en, wr_if.wr_addr);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_release_ctrl: got %b want 0000", ctrl);
    end
  endtask

  task automatic test_full_drain();
    start_job(4'd15, 4'd15, 8'h20, 8'h01, ACT_RELU6, 1'b0, 3'd3, 3'd5);
    for (int r = 0; r < 16; r++) begin
      exp_addr = {16{8'h20 + 8'(r)}};
      n_cmp++;
      if (ctrl !== 4'b1010) begin
        n_err++; $display("FAIL full_ctrl row %0d: got %b want 1010", r, ctrl);
      end
      n_cmp++;
      if (wr_if.row_num !== 4'(r)) begin
        n_err++; $display("FAIL full_row row %0d: got %0d want %0d", r, wr_if.row_num, r);
      end
      n_cmp++;
      if (wr_if.wr_addr !== exp_addr || wr_if.wr_en !== 16'hFFFF) begin
        n_err++;
        $display("FAIL full_bus row %0d: got addr %h en %h want addr %h en ffff",
                 r, wr_if.wr_addr[7:0], wr_if.wr_en, exp_addr[7:0]);
      end
      if (r == 0) begin
        n_cmp++;
        if ({wr_if.act_sel, sr_out, sc_out} !== {ACT_RELU6, 3'd3, 3'd5}) begin
          n_err++;
          $display("FAIL full_latched: got act %0d sr %0d sc %0d want 2 3 5", wr_if.act_sel, sr_out, sc_out);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ctrl !== 4'b0100 || wr_if.wr_en !== 16'h0) begin
      n_err++; $display("FAIL full_done: got ctrl %b en %h want 0100 0000", ctrl, wr_if.wr_en);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0000) begin
      n_err++; $display("FAIL full_after_done: got %b want 0000", ctrl);
    end
  endtask

  task automatic test_partial_clear();
    start_job(4'd3, 4'd4, 8'h50, 8'h01, 2'd3, 1'b1, 3'd1, 3'd2);
    for (int r = 0; r < 4; r++) begin
      n_cmp++;
      if (ctrl !== 4'b1010 || wr_if.wr_en !== 16'h001F || wr_if.row_num !== 4'(r)) begin
        n_err++;
        $display("FAIL partial_row %0d: got ctrl %b en %h row %0d want 1010 001f %0d",
                 r, ctrl, wr_if.wr_en, wr_if.row_num, r);
      end
      if (r == 0) begin
        n_cmp++;
        if (wr_if.act_sel !== ACT_NONE) begin
          n_err++; $display("FAIL partial_act_reserved: got %0d want 0", wr_if.act_sel);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ctrl !== 4'b1001 || wr_if.wr_en !== 16'h0) begin
      n_err++; $display("FAIL partial_clear: got ctrl %b en %h want 1001 0000", ctrl, wr_if.wr_en);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0100 || sr_out !== 3'd1 || sc_out !== 3'd2) begin
      n_err++; $display("FAIL partial_done: got ctrl %b sr %0d sc %0d want 0100 1 2", ctrl, sr_out, sc_out);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0000) begin
      n_err++; $display("FAIL partial_after_done: got %b want 0000", ctrl);
    end
  endtask

  task automatic test_backpressure();
    int   exp_row[8] = '{0, 1, 1, 1, 2, 2, 2, 3};
    logic rdy[8]     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    start_job(4'd3, 4'd0, 8'h30, 8'h01, ACT_RELU, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      wr_if.wr_ready = rdy[i];
      n_cmp++;
      if (ctrl !== 4'b1010 || wr_if.row_num !== 4'(exp_row[i]) ||
          wr_if.wr_addr[7:0] !== 8'h30 + 8'(exp_row[i]) || wr_if.wr_en !== 16'h0001) begin
        n_err++;
        $display("FAIL stall_cycle %0d: got ctrl %b row %0d addr %h en %h want 1010 %0d %h 0001",
                 i, ctrl, wr_if.row_num, wr_if.wr_addr[7:0], wr_if.wr_en, exp_row[i],
                 8'h30 + 8'(exp_row[i]));
      end
      @(negedge clk);
    end
    wr_if.wr_ready = 1'b1;
    n_cmp++;
    if (ctrl !== 4'b0100) begin
      n_err++; $display("FAIL stall_done: got %b want 0100", ctrl);
    end
    @(negedge clk);
  endtask

  task automatic test_stride_wrap();
`ifdef OUTPUT_DRAIN_ROW_STRIDE_EN
    logic [7:0] ea[4] = '{8'hF0, 8'hF8, 8'h00, 8'h08};
`else
    logic [7:0] ea[4] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
`endif
    start_job(4'd3, 4'd15, 8'hF0, 8'h08, ACT_NONE, 1'b0, 3'd0, 3'd0);
    for (int r = 0; r < 4; r++) begin
      exp_addr = {16{ea[r]}};
      n_cmp++;
      if (wr_if.wr_addr !== exp_addr || ctrl !== 4'b1010) begin
        n_err++;
        $display("FAIL stride_addr row %0d: got %h ctrl %b want %h 1010", r, wr_if.wr_addr[7:0], ctrl, ea[r]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ctrl !== 4'b0100) begin
      n_err++; $display("FAIL stride_done: got %b want 0100", ctrl);
    end
    @(negedge clk);
  endtask

  task automatic test_handshake();
    start_job(4'd2, 4'd7, 8'h60, 8'h01, ACT_RELU, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    // Row 1: a start here must be ignored.
    nrows = 4'd0; base = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (ctrl !== 4'b1010 || wr_if.row_num !== 4'd2 || wr_if.wr_addr[7:0] !== 8'h62) begin
      n_err++;
      $display("FAIL hs_ignored: got ctrl %b row %0d addr %h want 1010 2 62", ctrl, wr_if.row_num, wr_if.wr_addr[7:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0100) begin
      n_err++; $display("FAIL hs_done: got %b want 0100", ctrl);
    end
    // Start in the done cycle: accepted immediately.
    start_job(4'd1, 4'd1, 8'h40, 8'h01, ACT_RELU, 1'b0, 3'd0, 3'd0);
    n_cmp++;
    if (ctrl !== 4'b1010 || wr_if.row_num !== 4'd0 || wr_if.wr_addr[7:0] !== 8'h40 || wr_if.wr_en !== 16'h0003) begin
      n_err++;
      $display("FAIL hs_b2b_first: got ctrl %b row %0d addr %h en %h want 1010 0 40 0003",
               ctrl, wr_if.row_num, wr_if.wr_addr[7:0], wr_if.wr_en);
    end
    @(negedge clk);
    n_cmp++;
    if (wr_if.row_num !== 4'd1 || wr_if.wr_addr[7:0] !== 8'h41) begin
      n_err++; $display("FAIL hs_b2b_second: got row %0d addr %h want 1 41", wr_if.row_num, wr_if.wr_addr[7:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0100) begin
      n_err++; $display("FAIL hs_b2b_done: got %b want 0100", ctrl);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0000) begin
      n_err++; $display("FAIL hs_not_queued: got %b want 0000", ctrl);
    end
  endtask

  task automatic test_async_reset();
    start_job(4'd7, 4'd15, 8'h70, 8'h01, ACT_RELU, 1'b1, 3'd4, 3'd6);
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if (wr_if.row_num !== 4'd2) begin
      n_err++; $display("FAIL arst_pre_row: got %0d want 2", wr_if.row_num);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({ctrl, wr_if.act_sel, wr_if.row_num, sr_out, sc_out} !== 16'h0 ||
        {wr_if.wr_en, wr_if.wr_addr} !== 144'h0) begin
      n_err++;
      $display("FAIL arst_outputs: got ctrl %b row %0d en %h addr %h sr %0d want all zero",
               ctrl, wr_if.row_num, wr_if.wr_en, wr_if.wr_addr[7:0], sr_out);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (ctrl !== 4'b0000) begin
        n_err++; $display("FAIL arst_quiet cycle %0d: got %b want 0000", i, ctrl);
      end
      @(negedge clk);
    end
    start_job(4'd0, 4'd15, 8'h10, 8'h01, ACT_NONE, 1'b1, 3'd0, 3'd0);
    n_cmp++;
    if (ctrl !== 4'b1010 || wr_if.row_num !== 4'd0 || wr_if.wr_addr[7:0] !== 8'h10 || wr_if.wr_en !== 16'hFFFF) begin
      n_err++;
      $display("FAIL arst_restart_row: got ctrl %b row %0d addr %h en %h want 1010 0 10 ffff",
               ctrl, wr_if.row_num, wr_if.wr_addr[7:0], wr_if.wr_en);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b1001) begin
      n_err++; $display("FAIL arst_restart_clear: got %b want 1001", ctrl);
    end
    @(negedge clk);
    n_cmp++;
    if (ctrl !== 4'b0100) begin
      n_err++; $display("FAIL arst_restart_done: got %b want 0100", ctrl);
    end
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_partial_clear();
    test_backpressure();
    test_stride_wrap();
    test_handshake();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
